// File: rtl/frame_extremum_tracker_if.sv
// Sample-in / record-out handshake bundle for frame_extremum_tracker.
interface frame_extremum_tracker_if #(
  parameter int WIDTH = 6,
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sign;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_min_idx;
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W:0]   out_count;
  logic             out_signed;

  modport master (
    output in_valid, in_data, in_sign, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx,
           out_count, out_signed
  );

  modport slave (
    input  in_valid, in_data, in_sign, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx,
           out_count, out_signed
  );
endinterface

// File: rtl/frame_extremum_tracker.sv
// Running min/max (with first-occurrence index) over a frame of samples,
// compared signed or unsigned per frame; one registered record per frame.
module frame_extremum_tracker #(
  parameter int WIDTH     = 6,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  frame_extremum_tracker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;
    logic [IDX_W-1:0] mn_idx;
    logic [IDX_W-1:0] mx_idx;
    logic [IDX_W:0]   cnt;
    logic             sgn;
  } rec_t;

  localparam logic [IDX_W:0] LEN = (IDX_W+1)'(FRAME_LEN);

  state_t state_q, state_d;
  rec_t   acc_q, acc_d;   // running accumulator; cnt is the sample counter
  rec_t   out_q, out_d;   // record presented downstream

  // Flipping the MSB maps two's complement order onto unsigned order.
  function automatic logic less(input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b,
                                input logic             s);
    logic [WIDTH-1:0] ax, bx;
    ax = a;
    bx = b;
    if (s) begin
      ax[WIDTH-1] = ~a[WIDTH-1];
      bx[WIDTH-1] = ~b[WIDTH-1];
    end
    return ax < bx;
  endfunction

  logic           accept;
  logic [IDX_W:0] cnt_inc;

  assign bus.in_ready = (state_q != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cnt_inc      = acc_q.cnt + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d.mn     = bus.in_data;
          acc_d.mx     = bus.in_data;
          acc_d.mn_idx = '0;
          acc_d.mx_idx = '0;
          acc_d.cnt    = (IDX_W+1)'(1);
          acc_d.sgn    = bus.in_sign;
          if (bus.in_last || FRAME_LEN == 1) begin
            state_d = HOLD;
            out_d   = acc_d;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          // strict compares keep the earliest index on ties
          if (less(bus.in_data, acc_q.mn, acc_q.sgn)) begin
            acc_d.mn     = bus.in_data;
            acc_d.mn_idx = acc_q.cnt[IDX_W-1:0];
          end
          if (less(acc_q.mx, bus.in_data, acc_q.sgn)) begin
            acc_d.mx     = bus.in_data;
            acc_d.mx_idx = acc_q.cnt[IDX_W-1:0];
          end
          acc_d.cnt = cnt_inc;
          if (bus.in_last || cnt_inc == LEN) begin
            state_d = HOLD;
            out_d   = acc_d;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_min     = out_q.mn;
  assign bus.out_max     = out_q.mx;
  assign bus.out_min_idx = out_q.mn_idx;
  assign bus.out_max_idx = out_q.mx_idx;
  assign bus.out_count   = out_q.cnt;
  assign bus.out_signed  = out_q.sgn;
endmodule

// File: tb/tb_frame_extremum_tracker.sv
// Directed bench for frame_extremum_tracker: frames, ties, backpressure, reset.
module tb_frame_extremum_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  frame_extremum_tracker_if #(.WIDTH(6), .IDX_W(4)) bus ();

  frame_extremum_tracker #(.WIDTH(6), .FRAME_LEN(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // {min, max, min_idx, max_idx, count, signed} = 6+6+4+4+5+1 bits
  function automatic logic [25:0] rec();
    return {bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx,
            bus.out_count, bus.out_signed};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample and hold it until accepted (bounded).
  task automatic send(input logic [5:0] d, input logic s, input logic l);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sign  = s;
    bus.in_last  = l;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL consume: out_valid=%b in_ready=%b required 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || rec() !== 26'd0) begin
      bad++;
      $display("FAIL reset: out_valid=%b in_ready=%b rec=%h required 0/1/0",
               bus.out_valid, bus.in_ready, rec());
    end
  endtask

  task automatic test_unsigned();
    logic [5:0] v [16];
    v = '{6'd5, 6'd63, 6'd0, 6'd12, 6'd20, 6'd33, 6'd0, 6'd63,
          6'd8, 6'd1, 6'd40, 6'd2, 6'd50, 6'd3, 6'd9, 6'd7};
    for (int i = 0; i < 16; i++) begin
      send(v[i], 1'b0, 1'b0);
      if (i < 15) begin
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL unsigned_early_valid: idx=%0d out_valid=%b required 0", i, bus.out_valid);
        end
      end
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_latency: out_valid=%b in_ready=%b required 1/0",
               bus.out_valid, bus.in_ready);
    end
    total++;
    if (rec() !== {6'd0, 6'd63, 4'd2, 4'd1, 5'd16, 1'b0}) begin
      bad++;
      $display("FAIL unsigned_rec: got=%h required=%h", rec(),
               {6'd0, 6'd63, 4'd2, 4'd1, 5'd16, 1'b0});
    end
    consume();
  endtask

  task automatic test_signed();
    send(6'b111111, 1'b1, 1'b0);
    send(6'b011111, 1'b0, 1'b0);
    send(6'b100000, 1'b0, 1'b0);
    send(6'b000000, 1'b0, 1'b1);
    total++;
    if (bus.out_valid !== 1'b1 || rec() !== {6'b100000, 6'b011111, 4'd2, 4'd1, 5'd4, 1'b1}) begin
      bad++;
      $display("FAIL signed_rec: valid=%b got=%h required=%h", bus.out_valid, rec(),
               {6'b100000, 6'b011111, 4'd2, 4'd1, 5'd4, 1'b1});
    end
    consume();
  endtask

  // Ties plus mode latch, then 10 cycles of backpressure on the record.
  task automatic test_ties_backpressure();
    logic [25:0] exp_rec;
    exp_rec = {6'd3, 6'd9, 4'd1, 4'd0, 5'd4, 1'b1};
    send(6'd9, 1'b1, 1'b0);
    send(6'd3, 1'b0, 1'b0);
    send(6'd3, 1'b0, 1'b0);
    send(6'd9, 1'b0, 1'b1);
    total++;
    if (bus.out_valid !== 1'b1 || rec() !== exp_rec) begin
      bad++;
      $display("FAIL ties_rec: valid=%b got=%h required=%h", bus.out_valid, rec(), exp_rec);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 6'd55;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || rec() !== exp_rec) begin
        bad++;
        $display("FAIL backpressure: cyc=%0d valid=%b in_ready=%b rec=%h required 1/0/%h",
                 i, bus.out_valid, bus.in_ready, rec(), exp_rec);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    consume();
    total++;
    if (rec() !== exp_rec) begin
      bad++;
      $display("FAIL retain_after_consume: got=%h required=%h", rec(), exp_rec);
    end
  endtask

  task automatic test_single();
    send(6'd42, 1'b0, 1'b1);
    total++;
    if (bus.out_valid !== 1'b1 || rec() !== {6'd42, 6'd42, 4'd0, 4'd0, 5'd1, 1'b0}) begin
      bad++;
      $display("FAIL single_rec: valid=%b got=%h required=%h", bus.out_valid, rec(),
               {6'd42, 6'd42, 4'd0, 4'd0, 5'd1, 1'b0});
    end
    consume();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send(6'(i + 10), 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || rec() !== 26'd0) begin
      bad++;
      $display("FAIL reset_mid: valid=%b in_ready=%b rec=%h required 0/1/0",
               bus.out_valid, bus.in_ready, rec());
    end
    send(6'd1, 1'b0, 1'b0);
    send(6'd2, 1'b0, 1'b1);
    total++;
    if (bus.out_valid !== 1'b1 || rec() !== {6'd1, 6'd2, 4'd0, 4'd1, 5'd2, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_rec: valid=%b got=%h required=%h", bus.out_valid, rec(),
               {6'd1, 6'd2, 4'd0, 4'd1, 5'd2, 1'b0});
    end
    consume();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sign   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_ties_backpressure();
    test_single();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
